// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A PIC slice.
// Acknowledge FSM states and vector geometry.
package pic_pkg;

  localparam int VECTOR_BASE_W = 5;
  localparam logic [2:0] SPURIOUS_DEFAULT = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK1,
    WAIT2,
    ACK2,
    EOI
  } state_t;

endpackage

// File: rtl/pic_inta_sequencer_edge.sv
// INTA edge detector for the acknowledge sequencer.
// inta_n is already synchronous; idle-high history.
module inta_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic inta_n,
  output logic fall,
  output logic rise
);

  logic inta_prev;

  // Previous INTA level, idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      inta_prev <= 1'b1;
    end else begin
      inta_prev <= inta_n;
    end
  end

  assign fall = inta_prev & ~inta_n;
  assign rise = ~inta_prev & inta_n;

endmodule

// File: rtl/pic_inta_sequencer.sv
// 8086-mode interrupt-acknowledge sequencer.
// Raises INT, tracks two INTA pulses, drives vector.
module pic_inta_sequencer
  import pic_pkg::*;
#(
  parameter logic [2:0] SPURIOUS_LEVEL = SPURIOUS_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init_done,
  input  logic                       int_request,
  input  logic [2:0]                 int_index,
  input  logic [VECTOR_BASE_W-1:0]   icw2_t,
  input  logic                       icw4_aeoi,
  input  logic                       inta_n,
  output logic                       INT,
  output logic                       freezing,
  output logic                       read_priority,
  output logic [2:0]                 ack_index,
  output logic                       send_vector,
  output logic [VECTOR_BASE_W+2:0]   vector_out,
  output logic                       vector_oe,
  output logic                       auto_eoi,
  output logic                       spurious
);

  state_t state;
  state_t next_state;

  logic fall;
  logic rise;

  logic                     int_d;
  logic                     freezing_d;
  logic                     read_priority_d;
  logic [2:0]               ack_index_d;
  logic                     send_vector_d;
  logic [VECTOR_BASE_W+2:0] vector_out_d;
  logic                     vector_oe_d;
  logic                     auto_eoi_d;
  logic                     spurious_d;

  logic req_to_ack1;
  logic wait_to_ack2;

  inta_edge_detect u_edge (
    .clk    (clk),
    .reset  (reset),
    .inta_n (inta_n),
    .fall   (fall),
    .rise   (rise)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state; init_done low aborts from anywhere.
  always_comb begin
    next_state = state;
    if (!init_done) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (int_request) next_state = REQ;
        REQ:     if (fall) next_state = ACK1;
        ACK1:    if (rise) next_state = WAIT2;
        WAIT2:   if (fall) next_state = ACK2;
        ACK2: begin
          if (rise) begin
            next_state = (icw4_aeoi && !spurious) ? EOI : IDLE;
          end
        end
        EOI:     next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  assign req_to_ack1  = (state == REQ) && (next_state == ACK1);
  assign wait_to_ack2 = (state == WAIT2) && (next_state == ACK2);

  // Next output values; INT lags entry to REQ by one cycle.
  always_comb begin
    int_d           = (state == REQ) && (next_state == REQ);
    freezing_d      = next_state inside {ACK1, WAIT2, ACK2, EOI};
    read_priority_d = req_to_ack1 && int_request;
    send_vector_d   = wait_to_ack2;
    vector_oe_d     = (next_state == ACK2);
    auto_eoi_d      = (next_state == EOI);
    ack_index_d     = ack_index;
    spurious_d      = spurious;
    vector_out_d    = vector_out;
    if (!init_done) begin
      ack_index_d  = 3'd0;
      spurious_d   = 1'b0;
      vector_out_d = '0;
    end else begin
      if (req_to_ack1) begin
        ack_index_d = int_request ? int_index : SPURIOUS_LEVEL;
        spurious_d  = ~int_request;
      end else if (next_state == IDLE) begin
        spurious_d = 1'b0;
      end
      if (wait_to_ack2) begin
        vector_out_d = {icw2_t, ack_index};
      end
    end
  end

  // Output register block.
  always_ff @(posedge clk) begin
    if (reset) begin
      INT           <= 1'b0;
      freezing      <= 1'b0;
      read_priority <= 1'b0;
      ack_index     <= 3'd0;
      send_vector   <= 1'b0;
      vector_out    <= '0;
      vector_oe     <= 1'b0;
      auto_eoi      <= 1'b0;
      spurious      <= 1'b0;
    end else begin
      INT           <= int_d;
      freezing      <= freezing_d;
      read_priority <= read_priority_d;
      ack_index     <= ack_index_d;
      send_vector   <= send_vector_d;
      vector_out    <= vector_out_d;
      vector_oe     <= vector_oe_d;
      auto_eoi      <= auto_eoi_d;
      spurious      <= spurious_d;
    end
  end

endmodule

// File: doc/pic_inta_sequencer.md
# pic_inta_sequencer

Interrupt-acknowledge sequencer for the 8259A PIC, in 8086 mode. It sits between the priority resolver/in-service register and the CPU. It raises INT when the resolver has a pending request, then tracks the two-pulse INTA handshake. On the first pulse it freezes the resolver and latches the winning level. On the second pulse it drives the 8-bit interrupt vector onto the internal data bus, and issues an automatic EOI when AEOI mode is configured.

## Interface
Parameters:
- `SPURIOUS_LEVEL`, default 3'd7: level reported when the request vanishes before the first INTA pulse.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high reset.
- `init_done` in 1: ICW sequence complete. Low means the PIC is uninitialised or being re-initialised.
- `int_request` in 1: level from the priority resolver; an unmasked request outranks the in-service levels.
- `int_index` in 3: winning level from the priority resolver.
- `icw2_t` in 5: ICW2[7:3], the vector base.
- `icw4_aeoi` in 1: ICW4[1], auto-EOI enable.
- `inta_n` in 1: CPU acknowledge, active low, already synchronous to `clk`.
- `INT` out 1: interrupt request to the CPU.
- `freezing` out 1: holds the priority resolver stable during acknowledge.
- `read_priority` out 1: one-cycle pulse; tells the ISR to set bit `ack_index` and the IRR to clear it.
- `ack_index` out 3: level being acknowledged.
- `send_vector` out 1: one-cycle pulse at the start of vector drive.
- `vector_out` out 8: interrupt vector.
- `vector_oe` out 1: drive enable for the internal data bus.
- `auto_eoi` out 1: one-cycle EOI pulse to the ISR for `ack_index`.
- `spurious` out 1: the current acknowledge is spurious.

## Operation
- Edge detector: `inta_prev` register, reset to 1.
  - `fall` = `inta_prev` & ~`inta_n`.
  - `rise` = ~`inta_prev` & `inta_n`.
- State machine, all outputs registered.
  - IDLE: if `init_done` & `int_request`, go to REQ. INTA edges are ignored.
  - REQ: `INT`=1. On `fall`:
    - go to ACK1;
    - `ack_index` <= `int_request` ? `int_index` : `SPURIOUS_LEVEL`;
    - `spurious` <= ~`int_request`;
    - `read_priority` pulses only if not spurious.
  - ACK1: `INT`=0, `freezing`=1. On `rise`, go to WAIT2.
  - WAIT2: `freezing`=1. On `fall`:
    - go to ACK2;
    - `vector_out` <= {`icw2_t`, `ack_index`};
    - `vector_oe`=1;
    - `send_vector` pulses.
  - ACK2: `vector_oe`=1, `freezing`=1. On `rise`:
    - if `icw4_aeoi` & ~`spurious`, go to EOI;
    - otherwise go to IDLE.
  - EOI: `auto_eoi`=1 for one cycle, then IDLE.
- A request that drops while in REQ does not deassert `INT`; the acknowledge then proceeds as spurious (IR7 vector, no ISR set, no EOI).
- `init_done` low in any state: go to IDLE next cycle and clear all outputs. This is the abort/re-initialise path.
- A `fall` and `rise` can never occur in the same cycle; a glitch shorter than one cycle is not detected.

## Timing
- Reset values:
  - state IDLE, `inta_prev`=1;
  - `INT`=0, `freezing`=0, `read_priority`=0, `send_vector`=0, `vector_oe`=0, `auto_eoi`=0, `spurious`=0;
  - `ack_index`=0, `vector_out`=8'h00.
- Reset mid-handshake returns to IDLE in one cycle. Any further INTA pulses from the CPU are ignored until a new request.
- `INT` rises two cycles after `int_request` is first high in IDLE: one cycle for the transition to REQ, one for the registered output.
- `read_priority`, `send_vector` and `vector_oe` assert in the cycle after the detected edge; `INT` falls in that same cycle.
- `vector_oe` deasserts the cycle after `rise` in ACK2. `freezing` deasserts the cycle after leaving ACK2, or after EOI.
- A new request can raise `INT` at the earliest two cycles after returning to IDLE.

## Structure
- Shared package `pic_pkg`:
  - state enum {IDLE, REQ, ACK1, WAIT2, ACK2, EOI};
  - constant `VECTOR_BASE_W`=5;
  - default spurious level 3'd7.
- Sub-module `inta_edge_detect`: holds `inta_prev`, produces `fall` and `rise`, reset value 1.
- Everything else lives in one sequential FSM process plus an output register block.

## Test plan
- Normal acknowledge:
  - setup: `init_done`=1, `icw2_t`=5'b00001, `int_index`=3, `int_request`=1, AEOI off;
  - stimulus: two INTA pulses;
  - required: `INT` high, then one `read_priority` pulse with `ack_index`=3; `vector_out`=8'h0B while `vector_oe`=1; no `auto_eoi`; return to IDLE.
- AEOI:
  - same as normal acknowledge with `icw4_aeoi`=1 and `int_index`=6;
  - required: `vector_out`=8'h0E, then exactly one `auto_eoi` pulse after the second rising edge.
- Spurious:
  - `int_request` raised, then dropped while in REQ, then two INTA pulses;
  - required: `spurious`=1, no `read_priority`, `vector_out`=8'h0F, no EOI even with AEOI on.
- Reset mid-operation:
  - `reset` pulsed while in WAIT2;
  - required: all outputs at reset values next cycle; a subsequent INTA pulse with no request produces no response.
- Re-initialisation:
  - `init_done` dropped during ACK2;
  - required: `vector_oe` and `freezing` are 0 next cycle; `INT` stays 0 while `init_done`=0 even with `int_request`=1.
- Stray INTA: INTA pulses in IDLE -> all outputs remain 0.
